fft_unload: RTL and testbench
=============================

Name: fft_unload

Overview:
Streams FFT results out of the result RAM once the transform completes. This is the read-side counterpart of fft_load.
- After a start pulse, it walks bin addresses 0..NOUT-1 in natural order. Input was bit-reversed at load, so results already sit in natural order.
- Each bin is emitted on a valid/ready output stream, either as raw complex data or as unsigned magnitude-squared.
- It sits between the result RAM read port and the downstream spectrum consumer (display/serial packer).

Parameters:
width, 16, bits per real/imag component; RAM word is 2*width ({re, im}, re in upper half, two's complement).
N_2, 5, log2 of FFT points; RAM depth 2**N_2.
HALF, 1, 1: emit only bins 0..2**(N_2-1)-1 (real-input symmetry); 0: emit all 2**N_2 bins.
MAG, 0, 0: out_data = raw {re, im}; 1: out_data = re*re + im*im, unsigned.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; begin unloading (driven from fft done).
adr  out  N_2  result RAM read address.
rd  in  2*width  result RAM read data; combinational read of mem[adr], valid in the same cycle.
out_data  out  2*width  bin value (format per MAG).
out_idx  out  N_2  bin index of out_data.
out_valid  out  1  out_data/out_idx/out_last are valid.
out_ready  in  1  consumer accepts the beat when out_valid & out_ready at posedge.
out_last  out  1  high with the final bin's beat.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- NOUT = HALF ? 2**(N_2-1) : 2**N_2.
- Reset values: state IDLE, adr=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, done=0.
- States: IDLE, RUN, FIN.
- IDLE: start=1 at edge k -> RUN, adr=0, busy=1 after edge k. start is ignored outside IDLE.
- RUN uses a one-entry output register. Let "slot free" = ~out_valid | out_ready.
  - When the slot is free and fetch count < NOUT: capture rd (transformed per MAG) into out_data, set out_idx=adr, out_valid=1, out_last=(adr==NOUT-1), then adr<=adr+1.
  - When the slot is free and all NOUT bins are fetched: out_valid<=0.
  - adr never exceeds NOUT-1. The fetch counter is N_2+1 bits wide, so there is no wrap at NOUT=2**N_2.
- Latency: the first beat is valid after edge k+1. With out_ready held high, one bin is emitted per cycle and the last beat is valid after edge k+NOUT.
- Backpressure: while out_valid & ~out_ready, out_data, out_idx, out_last and adr hold stable.
- Acceptance of the out_last beat -> FIN. In FIN: out_valid=0, busy=0, done=1 for exactly one cycle, then IDLE.
- MAG=1: out_data = zero-extended sum of the signed squares re*re and im*im, full 2*width bits, no truncation. Worst case is 2*(2**(width-1))**2 = 2**(2*width-1), which fits. The square is registered into out_data in the same capture edge; no extra latency.
- MAG=0: out_data = rd verbatim.
- Reset asserted mid-RUN: the next edge returns to reset values with no done pulse; any pending beat is dropped.
- start and reset in the same cycle: reset wins.
- The block never writes the RAM. The caller must hold RAM contents stable while busy=1.

Test Plan:
1. width=16, N_2=5, HALF=1, MAG=0; RAM[i]={i, -i}; start, out_ready=1 -> 16 beats on consecutive cycles starting one cycle after start; beat j = {16'(j), -16'(j)}, out_idx=j; out_last only on j=15; done one cycle after beat 15; adr never exceeds 15.
2. HALF=0 with the same RAM -> 32 beats, out_idx 0..31, out_last on 31; busy drops with the done pulse.
3. MAG=1; RAM[0]={3,-4}, RAM[1]={16'h8000,16'h8000}, RAM[2]={16'h7FFF,0} -> out_data 25, 32'h80000000, 32'h3FFF0001.
4. HALF=1, MAG=0; out_ready toggles 1,0,0,1,... -> values stable while stalled; all 16 bins delivered in order with no duplicate or skip; done only after the last bin is accepted.
5. reset asserted after the 5th beat is accepted -> next cycle out_valid=0, busy=0, adr=0, and no done pulse. A fresh start then re-emits from bin 0.
6. start re-pulsed while busy at bin 7 -> ignored; sequence continues 8..15 with a single done. start and reset asserted together -> stays IDLE.

Source files
------------

// File: rtl/fft_unload_if.sv
// Output stream of fft_unload: one bin per beat on a valid/ready handshake.
interface fft_unload_if #(
    parameter int width = 16,
    parameter int N_2   = 5
);
    logic [2*width-1:0] out_data;
    logic [N_2-1:0]     out_idx;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;

    modport master (
        output out_data,
        output out_idx,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_idx,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/fft_unload.sv
// Walks result RAM bins 0..NOUT-1 in natural order and streams them out,
// either as raw {re, im} or as unsigned magnitude-squared.
module fft_unload #(
    parameter int width = 16,
    parameter int N_2   = 5,
    parameter bit HALF  = 1'b1,
    parameter bit MAG   = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [N_2-1:0]     adr,
    input  logic [2*width-1:0] rd,
    fft_unload_if.master       out,
    output logic               busy,
    output logic               done
);

    localparam int unsigned    NOUT   = HALF ? 2**(N_2-1) : 2**N_2;
    localparam logic [N_2:0]   NOUT_C = (N_2+1)'(NOUT);
    localparam logic [N_2-1:0] LAST_A = N_2'(NOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [N_2:0]       r_cnt;
    logic [N_2-1:0]     r_adr;
    logic [2*width-1:0] r_data;
    logic [N_2-1:0]     r_idx;
    logic               r_valid;
    logic               r_last;

    logic                      w_free;
    logic                      w_fetch;
    logic                      w_accept_last;
    logic signed [width-1:0]   w_re;
    logic signed [width-1:0]   w_im;
    logic signed [2*width-1:0] w_re_x;
    logic signed [2*width-1:0] w_im_x;
    logic signed [2*width-1:0] w_re_sq;
    logic signed [2*width-1:0] w_im_sq;
    logic [2*width-1:0]        w_mag;
    logic [2*width-1:0]        w_cap;

    // Squares of width-bit signed values fit in 2*width signed bits; the sum
    // may reach 2**(2*width-1), which is only representable read as unsigned.
    assign w_re    = rd[2*width-1:width];
    assign w_im    = rd[width-1:0];
    assign w_re_x  = {{width{w_re[width-1]}}, w_re};
    assign w_im_x  = {{width{w_im[width-1]}}, w_im};
    assign w_re_sq = w_re_x * w_re_x;
    assign w_im_sq = w_im_x * w_im_x;
    assign w_mag   = $unsigned(w_re_sq) + $unsigned(w_im_sq);
    assign w_cap   = MAG ? w_mag : rd;

    assign w_free        = ~r_valid | out.out_ready;
    assign w_fetch       = (r_state == RUN) & w_free & (r_cnt < NOUT_C);
    assign w_accept_last = (r_state == RUN) & r_valid & out.out_ready & r_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_accept_last) w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_adr   <= '0;
            r_data  <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_adr <= '0;
                        r_cnt <= '0;
                    end
                end
                RUN: begin
                    if (w_fetch) begin
                        r_data  <= w_cap;
                        r_idx   <= r_adr;
                        r_valid <= 1'b1;
                        r_last  <= (r_adr == LAST_A);
                        r_cnt   <= r_cnt + 1'b1;
                        // Address saturates on the final bin so it never leaves 0..NOUT-1.
                        if (r_adr != LAST_A) r_adr <= r_adr + 1'b1;
                    end else if (w_free) begin
                        r_valid <= 1'b0;
                    end
                end
                default: r_valid <= 1'b0;
            endcase
        end
    end

    assign adr           = r_adr;
    assign out.out_data  = r_data;
    assign out.out_idx   = r_idx;
    assign out.out_valid = r_valid;
    assign out.out_last  = r_last;
    assign busy          = (r_state == RUN);
    assign done          = (r_state == FIN);

endmodule

// File: tb/tb_fft_unload.sv
// Scoreboard bench for fft_unload: three configurations (half/raw, full/raw, half/mag).
module tb_fft_unload;

    localparam int W = 16;
    localparam int N = 5;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  i;
        logic        l;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        start;
    logic [2:0]        rst;
    logic [2:0]        rdy;
    logic [2:0][4:0]   adr;
    logic [2:0][31:0]  dat;
    logic [2:0][4:0]   idx;
    logic [2:0]        vld;
    logic [2:0]        lst;
    logic [2:0]        bsy;
    logic [2:0]        dn;
    logic [31:0]       ram [3][32];

    int    checks   = 0;
    int    failures = 0;
    int    active   = 0;
    int    pop_cnt  = 0;
    int    done_cnt = 0;
    beat_t q[$];

    fft_unload_if #(.width(W), .N_2(N)) if0 ();
    fft_unload_if #(.width(W), .N_2(N)) if1 ();
    fft_unload_if #(.width(W), .N_2(N)) if2 ();

    fft_unload #(.width(W), .N_2(N), .HALF(1'b1), .MAG(1'b0)) u0 (
        .clk(clk), .reset(rst[0]), .start(start[0]), .adr(adr[0]),
        .rd(ram[0][adr[0]]), .out(if0.master), .busy(bsy[0]), .done(dn[0]));
    fft_unload #(.width(W), .N_2(N), .HALF(1'b0), .MAG(1'b0)) u1 (
        .clk(clk), .reset(rst[1]), .start(start[1]), .adr(adr[1]),
        .rd(ram[1][adr[1]]), .out(if1.master), .busy(bsy[1]), .done(dn[1]));
    fft_unload #(.width(W), .N_2(N), .HALF(1'b1), .MAG(1'b1)) u2 (
        .clk(clk), .reset(rst[2]), .start(start[2]), .adr(adr[2]),
        .rd(ram[2][adr[2]]), .out(if2.master), .busy(bsy[2]), .done(dn[2]));

    assign if0.out_ready = rdy[0];
    assign if1.out_ready = rdy[1];
    assign if2.out_ready = rdy[2];
    assign dat = {if2.out_data,  if1.out_data,  if0.out_data};
    assign idx = {if2.out_idx,   if1.out_idx,   if0.out_idx};
    assign vld = {if2.out_valid, if1.out_valid, if0.out_valid};
    assign lst = {if2.out_last,  if1.out_last,  if0.out_last};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int nout(input int d);
        return (d == 1) ? 32 : 16;
    endfunction

    // Reference: bin j is RAM word j, or re^2 + im^2 of its signed halves.
    function automatic logic [31:0] model(input int d, input int j);
        logic [31:0] w;
        longint re;
        longint im;
        w = ram[d][j];
        if (d != 2) return w;
        re = longint'($signed(w[31:16]));
        im = longint'($signed(w[15:0]));
        return 32'(re * re + im * im);
    endfunction

    task automatic push_all(input int d);
        beat_t e;
        for (int j = 0; j < nout(d); j++) begin
            e.d = model(d, j);
            e.i = 5'(j);
            e.l = (j == nout(d) - 1);
            q.push_back(e);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted beat of the active DUT.
    beat_t       me;
    logic        pstall = 1'b0;
    logic [31:0] pd;
    logic [4:0]  pi;
    logic        pl;
    int          md;
    always @(negedge clk) begin
        md = active;
        if (!rst[md]) begin
            if (bsy[md]) chk("adr_range", 64'(adr[md] <= 5'(nout(md) - 1)), 64'd1);
            if (pstall && vld[md]) begin
                chk("stall_data", dat[md], pd);
                chk("stall_idx",  idx[md], pi);
                chk("stall_last", lst[md], pl);
            end
            if (vld[md] && rdy[md]) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_beat: got idx %0d expected no beat", idx[md]);
                end else begin
                    me = q.pop_front();
                    chk("beat_data", dat[md], me.d);
                    chk("beat_idx",  idx[md], me.i);
                    chk("beat_last", lst[md], me.l);
                    pop_cnt++;
                end
            end
            if (dn[md]) begin
                done_cnt++;
                chk("done_qempty", q.size(), 0);
            end
            pstall = vld[md] && !rdy[md];
            pd = dat[md];
            pi = idx[md];
            pl = lst[md];
        end else begin
            pstall = 1'b0;
        end
    end

    function automatic logic ready_val(input int mode, input int n);
        if (mode == 1) return (n % 3) == 0;
        if (mode == 2) return 1'($urandom_range(0, 1));
        return 1'b1;
    endfunction

    task automatic run(input int d, input int mode, input int pulse_n);
        int n;
        bit got;
        active   = d;
        done_cnt = 0;
        push_all(d);
        @(posedge clk); #1;
        start[d] = 1'b1;
        rdy[d]   = ready_val(mode, 0);
        n   = 0;
        got = 0;
        while (!got && n < 400) begin
            @(posedge clk); #1;
            start[d] = (n == pulse_n);
            rdy[d]   = ready_val(mode, n);
            @(negedge clk);
            n++;
            if (mode == 0 && n == 1) begin
                chk("busy_after_start", bsy[d], 1);
                chk("no_beat_yet", vld[d], 0);
            end
            if (mode == 0 && n == 2) chk("first_beat_latency", vld[d], 1);
            if (dn[d]) got = 1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected done within 400 cycles");
        end else begin
            chk("busy_low_at_done", bsy[d], 0);
            chk("valid_low_at_done", vld[d], 0);
            if (mode == 0) chk("done_latency", n, nout(d) + 2);
        end
        @(negedge clk);
        chk("done_one_cycle", dn[d], 0);
        chk("done_count", done_cnt, 1);
        chk("scoreboard_empty", q.size(), 0);
        start[d] = 1'b0;
        rdy[d]   = 1'b1;
        q.delete();
    endtask

    initial begin
        int n;
        start = '0;
        rst   = '1;
        rdy   = '1;
        for (int i = 0; i < 32; i++) begin
            ram[0][i] = {16'(i), 16'(-i)};
            ram[1][i] = {16'(i), 16'(-i)};
            ram[2][i] = $urandom;
        end
        ram[2][0] = {16'd3, 16'hFFFC};
        ram[2][1] = {16'h8000, 16'h8000};
        ram[2][2] = {16'h7FFF, 16'h0000};

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_valid", vld[d], 0);
            chk("rst_data",  dat[d], 0);
            chk("rst_idx",   idx[d], 0);
            chk("rst_last",  lst[d], 0);
            chk("rst_busy",  bsy[d], 0);
            chk("rst_done",  dn[d],  0);
            chk("rst_adr",   adr[d], 0);
        end
        rst = '0;

        run(0, 0, -1);
        run(1, 0, -1);
        run(2, 0, -1);
        run(0, 1, -1);
        for (int i = 0; i < 32; i++) ram[0][i] = $urandom;
        run(0, 2, -1);
        run(2, 2, -1);

        // Reset after the 5th accepted beat drops the run without a done pulse.
        active   = 0;
        done_cnt = 0;
        pop_cnt  = 0;
        push_all(0);
        @(posedge clk); #1 start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        n = 0;
        while (pop_cnt < 5 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (pop_cnt < 5) begin
            checks++;
            failures++;
            $display("FAIL reset_wait: got %0d beats expected 5", pop_cnt);
        end
        #1 rst[0] = 1'b1;
        @(posedge clk); #1 rst[0] = 1'b0;
        @(negedge clk);
        chk("midrst_valid", vld[0], 0);
        chk("midrst_busy",  bsy[0], 0);
        chk("midrst_adr",   adr[0], 0);
        chk("midrst_done",  dn[0],  0);
        chk("midrst_data",  dat[0], 0);
        q.delete();
        repeat (2) @(negedge clk);
        chk("midrst_no_done", done_cnt, 0);
        run(0, 0, -1);

        // start while busy at bin 7 is ignored.
        run(0, 0, 8);

        // start and reset together: reset wins, stays idle.
        @(posedge clk); #1;
        start[0] = 1'b1;
        rst[0]   = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        rst[0]   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("start_rst_busy",  bsy[0], 0);
            chk("start_rst_valid", vld[0], 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
